btn_event_fsm: RTL and testbench
================================

Name: btn_event_fsm

Overview:
- Downstream consumer of the 1-bit debouncer's clean output `db`.
- Classifies debounced button activity into short-press, long-press and double-click events, each a one-cycle pulse.
- Provides a held level and a wrapping event counter for UI/control logic.
- Sits between the debouncer and the application FSMs; runs in the same clock domain.

Parameters:
- CNT_W, 16, timer width; LONG_CYCLES, GAP_CYCLES and REPEAT_CYCLES must each be < 2^CNT_W.
- LONG_CYCLES, 20000, consecutive high samples that qualify a long press (>=2).
- GAP_CYCLES, 5000, low samples after a release during which a second press counts as a double click (>=2).
- REPEAT_CYCLES, 5000, auto-repeat period in LONG_HELD; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- db  in  1  debounced button level, synchronous to clk.
- short_p  out  1  one-cycle pulse: single short press.
- long_p  out  1  one-cycle pulse: long press qualified.
- double_p  out  1  one-cycle pulse: double click.
- held  out  1  level: high while in LONG_HELD.
- event_cnt  out  8  count of all emitted pulses.

Behaviour:
- Reset (reset=0), applied asynchronously:
  - state=IDLE, timer=0, db_q=1.
  - All outputs 0, event_cnt=0.
  - Resetting db_q to 1 means a button held through reset release produces no event until it is released and pressed again.
- Edge detection:
  - rise = db & ~db_q; fall = ~db & db_q.
  - db_q is registered every cycle.
- All outputs are registered. Each pulse is high for exactly the one cycle following the sample cycle that decided it.
- Timing notation:
  - k = first sample cycle with db high (rise).
  - f = first sample cycle with db low (fall).
- IDLE:
  - rise -> PRESSED, timer=1.
- PRESSED:
  - db high -> timer+1.
  - db high for LONG_CYCLES consecutive samples (k..k+LONG_CYCLES-1) -> LONG_HELD; long_p and held go high in cycle k+LONG_CYCLES.
  - fall before then -> WAIT_GAP, timer=0.
  - Boundary: a fall at sample k+LONG_CYCLES-1 means only LONG_CYCLES-1 high samples, so it takes the short path.
- LONG_HELD:
  - held=1.
  - fall -> IDLE; held goes 0 in cycle f+1; no further pulse.
- WAIT_GAP:
  - timer+1 per cycle.
  - rise at any sample f+1..f+GAP_CYCLES -> SECOND.
  - db low through sample f+GAP_CYCLES -> IDLE; short_p in cycle f+GAP_CYCLES+1.
- SECOND:
  - Waits for fall, of any press length; no long qualification.
  - On fall at f2 -> IDLE; double_p in cycle f2+1.
- event_cnt increments by 1 in the cycle any pulse is high; wraps 255->0.
- At most one pulse is high in any cycle.
- Timer saturates at 2^CNT_W-1; it never wraps.
- Reset mid-operation, in any state: everything returns to reset values; the pending event is discarded and no pulse is emitted.

Optional Feature:
- Macro: BTN_EVT_REPEAT_EN
- Defined:
  - In LONG_HELD, timer restarts at long_p.
  - long_p re-pulses every REPEAT_CYCLES cycles while db stays high.
  - Each repeat pulse increments event_cnt.
  - Repeats stop on fall; held behaves as without the macro.
- Undefined:
  - Exactly one long_p per long press.
  - REPEAT_CYCLES is ignored; no repeat logic is synthesized.

Test Plan:
Common settings: LONG_CYCLES=20, GAP_CYCLES=10, REPEAT_CYCLES=8, CNT_W=8.
1. reset=0 for 3 cycles with db=1, release reset, hold db=1 for 40 cycles, then drop it -> no pulses, held=0, event_cnt=0.
2. db high 5 cycles, then low -> short_p exactly one cycle, 11 cycles after f; event_cnt=1; no long_p or double_p.
3. db high 30 cycles -> long_p one cycle at k+20; held=1 from k+20 until f+1; no short_p; event_cnt=1. With BTN_EVT_REPEAT_EN: extra long_p at k+28, event_cnt=2.
4. Double click: db high 5, low 4, high 5, then low -> double_p one cycle at f2+1; short_p never asserted; event_cnt=1.
5. Boundaries:
   - db high 19 cycles -> short_p, not long_p.
   - Second rise at sample f+10 -> double_p.
   - Second rise at f+11 -> short_p at f+11, then the new press is handled from IDLE.
6. Drive reset low at f+5 in WAIT_GAP -> no short_p; all outputs 0; event_cnt=0. After 256 short presses, event_cnt wraps to 0.

Source files
------------

// File: rtl/btn_event_fsm.sv
// btn_event_fsm: turns a debounced button level into short/long/double-click pulses, a held level and an event counter.
// Optional long-press auto-repeat is enabled by defining BTN_EVT_REPEAT_EN.
module btn_event_fsm #(
    parameter int CNT_W         = 16,
    parameter int LONG_CYCLES   = 20000,
    parameter int GAP_CYCLES    = 5000,
    parameter int REPEAT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       db,
    output logic       short_p,
    output logic       long_p,
    output logic       double_p,
    output logic       held,
    output logic [7:0] event_cnt
);
    typedef enum logic [2:0] {IDLE, PRESSED, LONG_HELD, WAIT_GAP, SECOND} state_t;

    localparam logic [CNT_W-1:0] T_MAX  = '1;
    localparam logic [CNT_W-1:0] T_LONG = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] T_GAP  = CNT_W'(GAP_CYCLES - 1);
`ifdef BTN_EVT_REPEAT_EN
    localparam logic [CNT_W-1:0] T_REP  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    if (LONG_CYCLES < 2 || GAP_CYCLES < 2 || REPEAT_CYCLES < 1 ||
        LONG_CYCLES >= (1 << CNT_W) || GAP_CYCLES >= (1 << CNT_W) ||
        REPEAT_CYCLES >= (1 << CNT_W)) begin : g_bad_params
        $error("btn_event_fsm: timing parameters out of range for CNT_W");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
    logic             db_q;
    logic             short_q, long_q, double_q, held_q;
    logic             short_d, long_d, double_d, pulse_d;
    logic [7:0]       cnt_q;
    logic             rise, fall;

    assign rise      = db & ~db_q;
    assign fall      = ~db & db_q;
    assign timer_inc = (timer_q == T_MAX) ? timer_q : timer_q + CNT_W'(1);
    assign pulse_d   = short_d | long_d | double_d;

    // Timer meaning depends on state: high samples so far in PRESSED, low samples
    // since release in WAIT_GAP, cycles since the last long_p in LONG_HELD.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESSED;
                    timer_d = CNT_W'(1);
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_d = WAIT_GAP;
                    timer_d = '0;
                end else if (timer_q == T_LONG) begin
                    state_d = LONG_HELD;
                    timer_d = '0;
                    long_d  = 1'b1;
                end else begin
                    timer_d = timer_inc;
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    state_d = IDLE;
                    timer_d = '0;
                end
`ifdef BTN_EVT_REPEAT_EN
                else if (timer_q == T_REP) begin
                    timer_d = '0;
                    long_d  = 1'b1;
                end else begin
                    timer_d = timer_inc;
                end
`endif
            end
            WAIT_GAP: begin
                if (rise) begin
                    state_d = SECOND;
                    timer_d = '0;
                end else if (timer_q == T_GAP) begin
                    state_d = IDLE;
                    timer_d = '0;
                    short_d = 1'b1;
                end else begin
                    timer_d = timer_inc;
                end
            end
            SECOND: begin
                if (fall) begin
                    state_d  = IDLE;
                    double_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // db_q resets high so a button held through reset release is not seen as a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            db_q     <= 1'b1;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            held_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            db_q     <= db;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            held_q   <= (state_d == LONG_HELD);
            cnt_q    <= cnt_q + {7'd0, pulse_d};
        end
    end

    assign short_p   = short_q;
    assign long_p    = long_q;
    assign double_p  = double_q;
    assign held      = held_q;
    assign event_cnt = cnt_q;
endmodule

// File: tb/tb_btn_event_fsm.sv
// tb_btn_event_fsm: directed and random db waveforms checked cycle by cycle against an event-level model.
// The model classifies whole high/low runs of the stimulus and places each expected pulse at its absolute cycle.
module tb_btn_event_fsm;
    localparam int L = 20, G = 10, R = 8, MAXN = 4400;
`ifdef BTN_EVT_REPEAT_EN
    localparam int LONG_EVTS = 2;
`else
    localparam int LONG_EVTS = 1;
`endif

    logic       clk = 1'b0, reset = 1'b0, db = 1'b0;
    logic       short_p, long_p, double_p, held;
    logic [7:0] event_cnt;
    int         checks = 0, errors = 0;
    bit         seq[$];
    logic       o_s[MAXN], o_l[MAXN], o_d[MAXN], o_h[MAXN];
    logic [7:0] o_c[MAXN];
    bit         e_s[MAXN], e_l[MAXN], e_d[MAXN], e_h[MAXN];
    logic [7:0] e_c[MAXN];

    btn_event_fsm #(.CNT_W(8), .LONG_CYCLES(L), .GAP_CYCLES(G), .REPEAT_CYCLES(R)) dut (
        .clk(clk), .reset(reset), .db(db), .short_p(short_p), .long_p(long_p),
        .double_p(double_p), .held(held), .event_cnt(event_cnt)
    );

    always #5 clk = ~clk;

    task automatic add(bit v, int n);
        repeat (n) seq.push_back(v);
    endtask

    task automatic do_reset(bit v);
        reset = 1'b0;
        db = v;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        seq.delete();
    endtask

    // Index c of the observed arrays holds the outputs after c sampling edges.
    task automatic drive_seq();
        o_s[0] = short_p; o_l[0] = long_p; o_d[0] = double_p; o_h[0] = held; o_c[0] = event_cnt;
        foreach (seq[c]) begin
            db = seq[c];
            @(posedge clk);
            #1;
            o_s[c+1] = short_p; o_l[c+1] = long_p; o_d[c+1] = double_p; o_h[c+1] = held; o_c[c+1] = event_cnt;
            @(negedge clk);
        end
    endtask

    function automatic int run_len(int i, bit v);
        int n = 0;
        while (i + n < seq.size() && seq[i+n] == v) n++;
        return n;
    endfunction

    task automatic build_exp();
        int n = seq.size();
        int i = 0, k, h, f, g, f2;
        for (int c = 0; c <= n; c++) begin
            e_s[c] = 0; e_l[c] = 0; e_d[c] = 0; e_h[c] = 0;
        end
        while (i < n) begin
            if (!(i > 0 && seq[i] && !seq[i-1])) begin
                i++;
                continue;
            end
            k = i;
            h = run_len(k, 1'b1);
            f = k + h;
            if (h >= L) begin
                if (k + L <= n) e_l[k+L] = 1;
                for (int c = k + L; c <= f && c <= n; c++) e_h[c] = 1;
`ifdef BTN_EVT_REPEAT_EN
                for (int c = k + L + R; c <= f && c <= n; c += R) e_l[c] = 1;
`endif
                i = f + 1;
            end else begin
                g = run_len(f, 1'b0);
                if (g <= G) begin
                    f2 = f + g + run_len(f + g, 1'b1);
                    if (f2 + 1 <= n) e_d[f2+1] = 1;
                    i = f2 + 1;
                end else begin
                    if (f + G + 1 <= n) e_s[f+G+1] = 1;
                    i = f + G + 1;
                end
            end
        end
        e_c[0] = 0;
        for (int c = 1; c <= n; c++) e_c[c] = e_c[c-1] + 8'(e_s[c] | e_l[c] | e_d[c]);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        db = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({short_p, long_p, double_p, held, event_cnt} !== 12'd0) begin
            errors++;
            $display("FAIL reset_values got %b%b%b%b/%0d expected 0000/0", short_p, long_p, double_p, held, event_cnt);
        end
        reset = 1'b1;
        seq.delete();
        add(1, 40); add(0, 30);
        drive_seq(); build_exp();
        for (int c = 0; c <= seq.size(); c++) begin
            checks++;
            if ({o_s[c], o_l[c], o_d[c], o_h[c], o_c[c]} !== {e_s[c], e_l[c], e_d[c], e_h[c], e_c[c]}) begin
                errors++;
                $display("FAIL held_through_reset cyc=%0d got %b%b%b%b/%0d expected %b%b%b%b/%0d", c, o_s[c], o_l[c], o_d[c], o_h[c], o_c[c], e_s[c], e_l[c], e_d[c], e_h[c], e_c[c]);
            end
        end
        checks++;
        if (o_c[seq.size()] !== 8'd0) begin
            errors++;
            $display("FAIL held_through_reset_cnt got %0d expected 0", o_c[seq.size()]);
        end
    endtask

    task automatic test_short();
        int ns = 0, nx = 0;
        do_reset(0);
        add(0, 3); add(1, 5); add(0, 30);
        drive_seq(); build_exp();
        for (int c = 0; c <= seq.size(); c++) begin
            checks++;
            if ({o_s[c], o_l[c], o_d[c], o_h[c], o_c[c]} !== {e_s[c], e_l[c], e_d[c], e_h[c], e_c[c]}) begin
                errors++;
                $display("FAIL short_trace cyc=%0d got %b%b%b%b/%0d expected %b%b%b%b/%0d", c, o_s[c], o_l[c], o_d[c], o_h[c], o_c[c], e_s[c], e_l[c], e_d[c], e_h[c], e_c[c]);
            end
            ns += int'(o_s[c]);
            nx += int'(o_l[c]) + int'(o_d[c]);
        end
        checks++;
        if (o_s[19] !== 1'b1 || ns != 1 || nx != 0 || o_c[seq.size()] !== 8'd1) begin
            errors++;
            $display("FAIL short_event got short@19=%b shorts=%0d others=%0d cnt=%0d expected 1 1 0 1", o_s[19], ns, nx, o_c[seq.size()]);
        end
    endtask

    task automatic test_long();
        do_reset(0);
        add(0, 3); add(1, 30); add(0, 30);
        drive_seq(); build_exp();
        for (int c = 0; c <= seq.size(); c++) begin
            checks++;
            if ({o_s[c], o_l[c], o_d[c], o_h[c], o_c[c]} !== {e_s[c], e_l[c], e_d[c], e_h[c], e_c[c]}) begin
                errors++;
                $display("FAIL long_trace cyc=%0d got %b%b%b%b/%0d expected %b%b%b%b/%0d", c, o_s[c], o_l[c], o_d[c], o_h[c], o_c[c], e_s[c], e_l[c], e_d[c], e_h[c], e_c[c]);
            end
        end
        checks++;
        if (o_l[23] !== 1'b1 || o_h[22] !== 1'b0 || o_h[23] !== 1'b1 || o_h[33] !== 1'b1 || o_h[34] !== 1'b0 || o_c[seq.size()] !== 8'(LONG_EVTS)) begin
            errors++;
            $display("FAIL long_event got long@23=%b held@22,23,33,34=%b%b%b%b cnt=%0d expected 1 0110 %0d", o_l[23], o_h[22], o_h[23], o_h[33], o_h[34], o_c[seq.size()], LONG_EVTS);
        end
    endtask

    task automatic test_double();
        int ns = 0;
        do_reset(0);
        add(0, 3); add(1, 5); add(0, 4); add(1, 5); add(0, 30);
        drive_seq(); build_exp();
        for (int c = 0; c <= seq.size(); c++) begin
            checks++;
            if ({o_s[c], o_l[c], o_d[c], o_h[c], o_c[c]} !== {e_s[c], e_l[c], e_d[c], e_h[c], e_c[c]}) begin
                errors++;
                $display("FAIL double_trace cyc=%0d got %b%b%b%b/%0d expected %b%b%b%b/%0d", c, o_s[c], o_l[c], o_d[c], o_h[c], o_c[c], e_s[c], e_l[c], e_d[c], e_h[c], e_c[c]);
            end
            ns += int'(o_s[c]);
        end
        checks++;
        if (o_d[18] !== 1'b1 || ns != 0 || o_c[seq.size()] !== 8'd1) begin
            errors++;
            $display("FAIL double_event got double@18=%b shorts=%0d cnt=%0d expected 1 0 1", o_d[18], ns, o_c[seq.size()]);
        end
    endtask

    task automatic test_boundaries();
        int ns = 0, nl = 0, nd = 0;
        do_reset(0);
        add(0, 3); add(1, 19); add(0, 40);
        add(1, 5); add(0, 10); add(1, 5); add(0, 40);
        add(1, 5); add(0, 11); add(1, 5); add(0, 40);
        drive_seq(); build_exp();
        for (int c = 0; c <= seq.size(); c++) begin
            checks++;
            if ({o_s[c], o_l[c], o_d[c], o_h[c], o_c[c]} !== {e_s[c], e_l[c], e_d[c], e_h[c], e_c[c]}) begin
                errors++;
                $display("FAIL boundary_trace cyc=%0d got %b%b%b%b/%0d expected %b%b%b%b/%0d", c, o_s[c], o_l[c], o_d[c], o_h[c], o_c[c], e_s[c], e_l[c], e_d[c], e_h[c], e_c[c]);
            end
            ns += int'(o_s[c]); nl += int'(o_l[c]); nd += int'(o_d[c]);
        end
        checks++;
        if (o_s[33] !== 1'b1 || o_d[83] !== 1'b1 || o_s[138] !== 1'b1 || o_s[154] !== 1'b1 || ns != 3 || nl != 0 || nd != 1) begin
            errors++;
            $display("FAIL boundary_events got s33=%b d83=%b s138=%b s154=%b s/l/d=%0d/%0d/%0d expected 1 1 1 1 3/0/1", o_s[33], o_d[83], o_s[138], o_s[154], ns, nl, nd);
        end
    endtask

    task automatic test_reset_mid();
        int ns = 0;
        do_reset(0);
        add(0, 3); add(1, 5); add(0, 30); add(1, 5); add(0, 5);
        drive_seq(); build_exp();
        for (int c = 0; c <= seq.size(); c++) begin
            checks++;
            if ({o_s[c], o_l[c], o_d[c], o_h[c], o_c[c]} !== {e_s[c], e_l[c], e_d[c], e_h[c], e_c[c]}) begin
                errors++;
                $display("FAIL pre_reset_trace cyc=%0d got %b%b%b%b/%0d expected %b%b%b%b/%0d", c, o_s[c], o_l[c], o_d[c], o_h[c], o_c[c], e_s[c], e_l[c], e_d[c], e_h[c], e_c[c]);
            end
        end
        reset = 1'b0;
        db = 1'b0;
        #1;
        checks++;
        if ({short_p, long_p, double_p, held, event_cnt} !== 12'd0) begin
            errors++;
            $display("FAIL async_reset got %b%b%b%b/%0d expected 0000/0", short_p, long_p, double_p, held, event_cnt);
        end
        @(negedge clk);
        do_reset(0);
        add(0, 30);
        drive_seq(); build_exp();
        for (int c = 0; c <= seq.size(); c++) begin
            checks++;
            if ({o_s[c], o_l[c], o_d[c], o_h[c], o_c[c]} !== {e_s[c], e_l[c], e_d[c], e_h[c], e_c[c]}) begin
                errors++;
                $display("FAIL post_reset_trace cyc=%0d got %b%b%b%b/%0d expected %b%b%b%b/%0d", c, o_s[c], o_l[c], o_d[c], o_h[c], o_c[c], e_s[c], e_l[c], e_d[c], e_h[c], e_c[c]);
            end
            ns += int'(o_s[c]);
        end
        checks++;
        if (ns != 0) begin
            errors++;
            $display("FAIL discarded_short got %0d short pulses expected 0", ns);
        end
    endtask

    task automatic test_wrap();
        int ns = 0;
        do_reset(0);
        add(0, 3);
        repeat (256) begin
            add(1, 3); add(0, 12);
        end
        add(0, 30);
        drive_seq(); build_exp();
        for (int c = 0; c <= seq.size(); c++) begin
            checks++;
            if ({o_s[c], o_l[c], o_d[c], o_h[c], o_c[c]} !== {e_s[c], e_l[c], e_d[c], e_h[c], e_c[c]}) begin
                errors++;
                $display("FAIL wrap_trace cyc=%0d got %b%b%b%b/%0d expected %b%b%b%b/%0d", c, o_s[c], o_l[c], o_d[c], o_h[c], o_c[c], e_s[c], e_l[c], e_d[c], e_h[c], e_c[c]);
            end
            ns += int'(o_s[c]);
        end
        checks++;
        if (ns != 256 || o_c[seq.size()] !== 8'd0) begin
            errors++;
            $display("FAIL cnt_wrap got shorts=%0d cnt=%0d expected 256 0", ns, o_c[seq.size()]);
        end
    endtask

    task automatic test_random();
        repeat (5) begin
            do_reset(0);
            add(0, 3);
            repeat (15) begin
                add(1, int'($urandom_range(1, 32)));
                add(0, int'($urandom_range(1, 14)));
            end
            add(0, 40);
            drive_seq(); build_exp();
            for (int c = 0; c <= seq.size(); c++) begin
                checks++;
                if ({o_s[c], o_l[c], o_d[c], o_h[c], o_c[c]} !== {e_s[c], e_l[c], e_d[c], e_h[c], e_c[c]}) begin
                    errors++;
                    $display("FAIL random_trace cyc=%0d got %b%b%b%b/%0d expected %b%b%b%b/%0d", c, o_s[c], o_l[c], o_d[c], o_h[c], o_c[c], e_s[c], e_l[c], e_d[c], e_h[c], e_c[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_double();
        test_boundaries();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
